// File: rtl/fifo_a_sync_if.sv
// Handshake/data bundle between the SDRAM fetch engine (master) and the
// audio sample FIFO (slave).
interface fifo_a_sync_if #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 11
);
  logic [WIDTH-1:0]  data;
  logic              wrreq;
  logic              rdreq;
  logic [WIDTH-1:0]  q;
  logic [ADDR_W-1:0] wrusedw;
  logic              rdempty;
  logic              wrfull;

  modport master (output data, wrreq, rdreq, input q, wrusedw, rdempty, wrfull);
  modport slave  (input data, wrreq, rdreq, output q, wrusedw, rdempty, wrfull);
endinterface

// File: rtl/fifo_a_sync.sv
// Single-clock show-ahead FIFO for audio samples; the head word is on q
// as soon as it is stored, and the last popped word is held while empty.
module fifo_a_sync #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 11
) (
  input  logic         Clk,
  input  logic         reset,
  fifo_a_sync_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_W;

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [ADDR_W:0]   cnt, cnt_nxt;
  logic              rdempty_r, wrfull_r;
  logic [WIDTH-1:0]  q_hold;
  logic              push, pop;

  // Acceptance uses registered flags, so a push at full is dropped even if a pop frees space.
  assign push = bus.wrreq && !wrfull_r;
  assign pop  = bus.rdreq && !rdempty_r;

  always_comb begin
    cnt_nxt = cnt;
    if (push && !pop)      cnt_nxt = cnt + (ADDR_W+1)'(1);
    else if (pop && !push) cnt_nxt = cnt - (ADDR_W+1)'(1);
  end

  always_ff @(posedge Clk) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      cnt       <= '0;
      rdempty_r <= 1'b1;
      wrfull_r  <= 1'b0;
      q_hold    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (pop) begin
        rd_ptr <= rd_ptr + ADDR_W'(1);
        q_hold <= mem[rd_ptr];
      end
      cnt       <= cnt_nxt;
      rdempty_r <= (cnt_nxt == '0);
      wrfull_r  <= (cnt_nxt == (ADDR_W+1)'(DEPTH));
    end
  end

  // Storage is never cleared; q only exposes it while the FIFO is non-empty.
  always_ff @(posedge Clk) begin
    if (push && !reset) mem[wr_ptr] <= bus.data;
  end

  assign bus.q       = rdempty_r ? q_hold : mem[rd_ptr];
  assign bus.wrusedw = cnt[ADDR_W-1:0];
  assign bus.rdempty = rdempty_r;
  assign bus.wrfull  = wrfull_r;
endmodule

// File: tb/tb_fifo_a_sync.sv
// Directed + randomized bench for fifo_a_sync against a queue-based model.
module tb_fifo_a_sync;
  localparam int WIDTH  = 16;
  localparam int ADDR_W = 11;
  localparam int DEPTH  = 1 << ADDR_W;

  logic Clk = 1'b0;
  logic reset = 1'b1;
  always #5 Clk = ~Clk;

  fifo_a_sync_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) bus ();
  fifo_a_sync #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (.Clk(Clk), .reset(reset), .bus(bus.slave));

  logic [WIDTH-1:0] mq [$];
  logic [WIDTH-1:0] last_q;
  int passed = 0;
  int total  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic chk_model(input string tag);
    logic [WIDTH-1:0] eq;
    eq = (mq.size() == 0) ? last_q : mq[0];
    chk({tag, ".rdempty"}, 32'(bus.rdempty), 32'(mq.size() == 0));
    chk({tag, ".wrfull"},  32'(bus.wrfull),  32'(mq.size() == DEPTH));
    chk({tag, ".wrusedw"}, 32'(bus.wrusedw), 32'(mq.size() % DEPTH));
    chk({tag, ".q"},       32'(bus.q),       32'(eq));
  endtask

  // One clock: drive, let the edge happen, advance the model, check at negedge.
  task automatic step(input string tag, input logic r, input logic w, input logic rd,
                      input logic [WIDTH-1:0] d);
    bit pa, po;
    reset = r; bus.wrreq = w; bus.rdreq = rd; bus.data = d;
    @(posedge Clk);
    if (r) begin
      mq.delete();
      last_q = '0;
    end else begin
      pa = w && (mq.size() < DEPTH);
      po = rd && (mq.size() > 0);
      if (po) last_q = mq.pop_front();
      if (pa) mq.push_back(d);
    end
    @(negedge Clk);
    chk_model(tag);
  endtask

  initial begin
    logic [WIDTH-1:0] w0, nw;
    int pushed, cyc;
    bus.wrreq = 1'b1; bus.rdreq = 1'b1; bus.data = '0;
    mq.delete(); last_q = '0;

    // reset with requests active
    step("rst0", 1, 1, 1, 16'h1234);
    step("rst1", 1, 1, 1, 16'h5678);
    chk("rst.q_zero", 32'(bus.q), 32'h0);

    // ordered fill/drain of 1700 words
    for (int i = 0; i < 1700; i++) step("fill", 0, 1, 0, 16'(i));
    chk("fill.wrusedw1700", 32'(bus.wrusedw), 32'd1700);
    for (int i = 0; i < 1700; i++) begin
      chk("drain.head", 32'(bus.q), 32'(i));
      step("drain", 0, 0, 1, 16'h0);
    end
    chk("drain.empty", 32'(bus.rdempty), 32'd1);
    chk("drain.hold", 32'(bus.q), 32'h06A3);

    // show-ahead
    step("sa.push", 0, 1, 0, 16'hBEEF);
    chk("sa.q", 32'(bus.q), 32'hBEEF);
    chk("sa.rdempty", 32'(bus.rdempty), 32'd0);
    step("sa.pop", 0, 0, 1, 16'h0);

    // full boundary
    w0 = 16'($urandom);
    step("full.fill", 0, 1, 0, w0);
    for (int i = 1; i < DEPTH; i++) step("full.fill", 0, 1, 0, 16'($urandom));
    chk("full.wrfull", 32'(bus.wrfull), 32'd1);
    chk("full.wrusedw0", 32'(bus.wrusedw), 32'd0);
    step("full.extra", 0, 1, 0, 16'hDEAD);
    chk("full.word0", 32'(bus.q), 32'(w0));
    step("full.pop", 0, 0, 1, 16'h0);
    chk("full.last", 32'(last_q), 32'(w0));
    step("full.refill", 0, 1, 0, 16'($urandom));
    step("full.both", 0, 1, 1, 16'hDEAD);
    chk("full.both.wrusedw", 32'(bus.wrusedw), 32'd2047);
    while (mq.size() > 0) step("full.drain", 0, 0, 1, 16'h0);

    // simultaneous at cnt=5, then underflow
    for (int i = 0; i < 5; i++) step("sim.fill", 0, 1, 0, 16'($urandom));
    for (int i = 0; i < 10; i++) begin
      step("sim.both", 0, 1, 1, 16'($urandom));
      chk("sim.wrusedw5", 32'(bus.wrusedw), 32'd5);
    end
    while (mq.size() > 0) step("sim.drain", 0, 0, 1, 16'h0);
    step("uflow", 0, 0, 1, 16'h0);
    chk("uflow.wrusedw", 32'(bus.wrusedw), 32'd0);

    // random traffic around occupancy 100 across several pointer wraps
    pushed = 0; cyc = 0;
    while (pushed < 3000 && cyc < 20000) begin
      logic w, rd;
      w  = (mq.size() < 100) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      rd = (mq.size() > 100) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      if (w) pushed++;
      step("wrap", 0, w, rd, 16'($urandom));
      cyc++;
    end
    chk("wrap.budget", 32'(pushed >= 3000), 32'd1);

    // mid-operation reset at cnt=100
    while (mq.size() < 100) step("mr.fill", 0, 1, 0, 16'($urandom));
    while (mq.size() > 100) step("mr.trim", 0, 0, 1, 16'h0);
    step("mr.reset", 1, 1, 1, 16'h7777);
    chk("mr.empty", 32'(bus.rdempty), 32'd1);
    nw = 16'($urandom);
    step("mr.push", 0, 1, 0, nw);
    chk("mr.newq", 32'(bus.q), 32'(nw));
    step("mr.pop", 0, 0, 1, 16'h0);
    chk("mr.hold", 32'(bus.q), 32'(nw));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
